// File: rtl/regfile_wb_sched.sv
// Writeback scheduler: busy scoreboard, two-requester arbiter, one RF port.
// Define REGFILE_WB_RR_EN for round-robin arbitration (default: load wins).
module regfile_wb_sched #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid,
  input  logic [4:0]       iss_rd,
  input  logic [4:0]       iss_rs1,
  input  logic [4:0]       iss_rs2,
  output logic             iss_stall,
  input  logic             wb0_valid,
  input  logic [4:0]       wb0_rd,
  input  logic [WIDTH-1:0] wb0_data,
  output logic             wb0_ready,
  input  logic             wb1_valid,
  input  logic [4:0]       wb1_rd,
  input  logic [WIDTH-1:0] wb1_data,
  output logic             wb1_ready,
  output logic [4:0]       rf_rd,
  output logic [WIDTH-1:0] rf_rd_data,
  output logic             rf_rd_we
);

  // bit 0 stays zero so x0 never reads as busy
  logic [31:0] busy;
  logic [31:0] busy_nxt;
  logic        gnt0;
  logic        gnt1;
  logic        hs;
  logic [4:0]       sel_rd;
  logic [WIDTH-1:0] sel_data;

  function automatic logic hit(
    input logic [31:0] b,
    input logic [4:0]  r
  );
    return (r != 5'd0) && b[r];
  endfunction

  assign iss_stall = !rst && iss_valid &&
                     (hit(busy, iss_rs1) ||
                      hit(busy, iss_rs2) ||
                      hit(busy, iss_rd));

`ifdef REGFILE_WB_RR_EN
  logic pref1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (wb0_valid && wb1_valid) begin
        gnt1 = pref1;
        gnt0 = !pref1;
      end else begin
        gnt0 = wb0_valid;
        gnt1 = wb1_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      pref1 <= 1'b0;
    else if (gnt0)
      pref1 <= 1'b1;
    else if (gnt1)
      pref1 <= 1'b0;
  end
`else
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      gnt1 = wb1_valid;
      gnt0 = wb0_valid && !wb1_valid;
    end
  end
`endif

  assign wb0_ready = gnt0;
  assign wb1_ready = gnt1;
  assign hs        = gnt0 || gnt1;
  assign sel_rd    = gnt1 ? wb1_rd : wb0_rd;
  assign sel_data  = gnt1 ? wb1_data : wb0_data;

  // clear first so a same-cycle issue set wins
  always_comb begin
    busy_nxt = busy;
    if (rf_rd_we)
      busy_nxt[rf_rd] = 1'b0;
    if (iss_valid && !iss_stall && iss_rd != 5'd0)
      busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_rd_we   <= 1'b0;
      rf_rd      <= 5'd0;
      rf_rd_data <= '0;
    end else if (hs && sel_rd != 5'd0) begin
      rf_rd_we   <= 1'b1;
      rf_rd      <= sel_rd;
      rf_rd_data <= sel_data;
    end else begin
      rf_rd_we   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Scoreboard bench for regfile_wb_sched; RF writes checked by a monitor.
module tb_regfile_wb_sched;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         iss_valid;
  logic [4:0]   iss_rd, iss_rs1, iss_rs2;
  logic         iss_stall;
  logic         wb0_valid, wb1_valid;
  logic [4:0]   wb0_rd, wb1_rd;
  logic [W-1:0] wb0_data, wb1_data;
  logic         wb0_ready, wb1_ready;
  logic [4:0]   rf_rd;
  logic [W-1:0] rf_rd_data;
  logic         rf_rd_we;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W+4:0] exp_q[$];

  regfile_wb_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_stall(iss_stall),
    .wb0_valid(wb0_valid), .wb0_rd(wb0_rd),
    .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_rd(wb1_rd),
    .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .rf_rd(rf_rd), .rf_rd_data(rf_rd_data),
    .rf_rd_we(rf_rd_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [4:0] rd, input logic [W-1:0] d);
    exp_q.push_back({rd, d});
  endtask

  task automatic idle();
    iss_valid = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
    wb0_valid = 0; wb0_rd = 0; wb0_data = 0;
    wb1_valid = 0; wb1_rd = 0; wb1_data = 0;
  endtask

  // monitor: every RF write must match the oldest expected one
  always @(negedge clk) begin
    logic [W+4:0] e;
    if (!rst && rf_rd_we) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got rd=%0d data=%h want none",
                 rf_rd, rf_rd_data);
      end else begin
        e = exp_q.pop_front();
        if ({rf_rd, rf_rd_data} !== e) begin
          n_bad++;
          $display("FAIL rf_write: got rd=%0d data=%h want rd=%0d data=%h",
                   rf_rd, rf_rd_data, e[W+4:W], e[W-1:0]);
        end
      end
    end
  end

  initial begin
    idle();
    rst = 1;
    iss_valid = 1; iss_rs1 = 7; iss_rs2 = 7; iss_rd = 7;
    wb0_valid = 1; wb0_rd = 2; wb0_data = 32'h1;
    cyc();
    settle();
    chk("rst_ready0", wb0_ready, 0);
    chk("rst_stall", iss_stall, 0);
    chk("rst_we", rf_rd_we, 0);
    chk("rst_rd", rf_rd, 0);
    chk("rst_data", rf_rd_data, 0);
    idle();
    cyc();
    rst = 0;

    // simultaneous requesters
    wb0_valid = 1; wb0_rd = 3; wb0_data = 32'hAAAA;
    wb1_valid = 1; wb1_rd = 4; wb1_data = 32'h5555;
    settle();
`ifdef REGFILE_WB_RR_EN
    chk("arb1_ready0", wb0_ready, 1);
    chk("arb1_ready1", wb1_ready, 0);
    push(3, 32'hAAAA);
    cyc();
    wb0_valid = 0;
    settle();
    chk("arb2_ready1", wb1_ready, 1);
    push(4, 32'h5555);
`else
    chk("arb1_ready1", wb1_ready, 1);
    chk("arb1_ready0", wb0_ready, 0);
    push(4, 32'h5555);
    cyc();
    wb1_valid = 0;
    settle();
    chk("arb2_ready0", wb0_ready, 1);
    push(3, 32'hAAAA);
`endif
    cyc();
    idle();
    settle();
    chk("arb_we1", rf_rd_we, 1);
    cyc();

    // RAW stall on x5
    iss_valid = 1; iss_rd = 5;
    settle();
    chk("iss5_stall", iss_stall, 0);
    cyc();
    iss_rd = 0; iss_rs1 = 5;
    wb0_valid = 1; wb0_rd = 5; wb0_data = 32'h55;
    settle();
    chk("raw_stall", iss_stall, 1);
    chk("raw_ready0", wb0_ready, 1);
    push(5, 32'h55);
    cyc();
    wb0_valid = 0;
    settle();
    chk("raw_we", rf_rd_we, 1);
    chk("raw_stall_we", iss_stall, 1);
    cyc();
    settle();
    chk("raw_stall_clr", iss_stall, 0);
    idle();
    cyc();

    // writeback to x0
    wb0_valid = 1; wb0_rd = 0; wb0_data = 32'h1234;
    settle();
    chk("x0_ready0", wb0_ready, 1);
    cyc();
    idle();
    settle();
    chk("x0_we", rf_rd_we, 0);
    chk("x0_hold_rd", rf_rd, 5);
    chk("x0_hold_data", rf_rd_data, 32'h55);
    cyc();

    // issue set beats writeback clear on x7
    wb1_valid = 1; wb1_rd = 7; wb1_data = 32'h77;
    settle();
    chk("x7_ready1", wb1_ready, 1);
    push(7, 32'h77);
    cyc();
    wb1_valid = 0;
    iss_valid = 1; iss_rd = 7;
    settle();
    chk("x7_we", rf_rd_we, 1);
    chk("x7_iss_stall", iss_stall, 0);
    cyc();
    iss_rd = 0; iss_rs1 = 7;
    settle();
    chk("x7_busy", iss_stall, 1);
    wb0_valid = 1; wb0_rd = 7; wb0_data = 32'h70;
    settle();
    push(7, 32'h70);
    cyc();
    wb0_valid = 0;
    cyc();
    settle();
    chk("x7_clr", iss_stall, 0);
    idle();
    cyc();

    // x0 never busy
    iss_valid = 1;
    settle();
    chk("x0_iss_a", iss_stall, 0);
    cyc();
    settle();
    chk("x0_iss_b", iss_stall, 0);
    idle();
    cyc();

    // reset during a handshake
    iss_valid = 1; iss_rd = 7;
    cyc();
    iss_rs1 = 7; iss_rs2 = 7;
    settle();
    chk("pre_rst_stall", iss_stall, 1);
    rst = 1;
    wb0_valid = 1; wb0_rd = 7; wb0_data = 32'h99;
    settle();
    chk("rst_hs_ready0", wb0_ready, 0);
    chk("rst_hs_stall", iss_stall, 0);
    cyc();
    rst = 0;
    wb0_valid = 0;
    settle();
    chk("post_rst_we", rf_rd_we, 0);
    chk("post_rst_stall", iss_stall, 0);
    cyc();
    idle();
    settle();
    chk("post_rst_we2", rf_rd_we, 0);

    repeat (3) cyc();
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
